uart_rx_checker: RTL and testbench
==================================

// Module: uart_rx_checker
// PURPOSE
// - 8N1 UART receiver and loopback checker placed directly downstream of the TX controller's serial 'tx' line
//   (looped back on the board, or wired in the bench).
// - Recovers each byte and reports byte count, framing errors and data mismatches against the byte the TX side
//   has latched.
// - Its counters feed the seven-segment display path as a self-test of the transmitter.
// PARAMETERS
// - CLKS_PER_BIT  10416  system_clock cycles per bit (100 MHz / 9600 Bd); must be >= 4.
// - CNT_W         16     width of rx_byte_count and err_count.
// PORTS
// - system_clock   in   1      single clock for all logic.
// - cpu_rst_n      in   1      asynchronous, active-low reset.
// - rx             in   1      serial input, idle high, asynchronous to system_clock.
// - expected_data  in   8      reference byte, compared at the stop-bit sample.
// - rx_data        out  8      last good byte; holds its value until the next good byte.
// - rx_valid       out  1      1-cycle pulse when rx_data updates.
// - frame_error    out  1      1-cycle pulse when the stop bit samples 0.
// - mismatch       out  1      1-cycle pulse with rx_valid when the received byte != expected_data.
// - rx_busy        out  1      high in any state except IDLE.
// - rx_byte_count  out  CNT_W  good bytes received; wraps at 2^CNT_W.
// - err_count      out  CNT_W  framing errors + mismatches; saturates at all-ones.
// BEHAVIOUR
// - Reset: all outputs 0; synchroniser flops = 1; FSM = IDLE; bit counter and shift register = 0.
//   Reset mid-frame aborts the frame with no pulses.
// - rx passes a 2-flop synchroniser (rx_s) before any use: 2 cycles of input latency.
// - Bit timer: tick counter 0..CLKS_PER_BIT-1, cleared on every state entry.
// - FSM states:
//   - IDLE: rx_s==0 -> START.
//   - START: at tick==CLKS_PER_BIT/2-1, sample rx_s.
//     - 0 -> DATA (timer cleared, so all later samples fall mid-bit).
//     - 1 -> IDLE (glitch rejected; no pulse, no count).
//   - DATA: at tick==CLKS_PER_BIT-1, shift rx_s in LSB-first; bit_idx 0..7. After bit 7 -> STOP.
//   - STOP: at tick==CLKS_PER_BIT-1, sample rx_s.
//     - 1 -> rx_data<=shift, rx_valid=1, rx_byte_count++, mismatch=(shift!=expected_data), err_count++ if mismatch; -> IDLE.
//     - 0 -> frame_error=1, err_count++, rx_data unchanged; -> BREAK.
//   - BREAK: stay until rx_s==1, then -> IDLE. A line held low produces exactly one frame_error.
// - Latency: rx_valid rises 9.5 bit times + 2 cycles after the rx start edge.
//   Back-to-back frames: IDLE is re-entered mid-stop-bit, so the next start edge is caught at full throughput.
// - frame_error and rx_valid never assert in the same cycle.
// - mismatch is only ever high together with rx_valid.
// - expected_data is sampled only at the stop-bit sample cycle.
// - Simultaneous increment of err_count by mismatch and frame_error cannot occur (exclusive by construction).
// - rx_byte_count: all-ones +1 -> 0.
// - err_count: held at all-ones once reached.
// - Widths: tick counter $clog2(CLKS_PER_BIT) bits; bit_idx 3 bits. No arithmetic overflow except the
//   specified wrap/saturate.
// STRUCTURE
// - Shared package uart_pkg:
//   - typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
//   - localparam UART_DATA_BITS = 8;
//   - default CLKS_PER_BIT, shared with the TX clock divider.
// - One sub-module: sync_2ff (1-bit 2-flop synchroniser, reset value parameter = 1). FSM, timer and counters stay inline.
// - Integration in the chip top:
//   - rx <- tx;
//   - expected_data <- data_latch;
//   - rx_byte_count[7:0] / err_count[7:0] made available to value2disp.
// TESTING (bench with CLKS_PER_BIT=16)
// - Send 0x55, expected_data=0x55
//   -> rx_valid 1 cycle, rx_data=0x55, mismatch=0, rx_byte_count=1, err_count=0.
// - Frames 0xA5 then 0x3C with no idle gap, expected_data=0xA5 then 0x3C
//   -> two rx_valid pulses 160 cycles apart, rx_byte_count=2.
// - rx low pulse of 6 cycles from idle
//   -> FSM returns to IDLE, no pulses, counters unchanged, rx_busy falls by cycle 10.
// - 0xF0 with stop bit forced 0, line then held low for 40 cycles
//   -> one frame_error pulse, err_count=1, rx_data unchanged, BREAK until rx high.
// - Send 0x81 with expected_data=0x18
//   -> rx_valid and mismatch together, rx_data=0x81, err_count=1, rx_byte_count=1.
// - Assert cpu_rst_n low during bit 4 of a frame, release, then send 0x42
//   -> no pulse for the aborted frame, all outputs 0 after reset, 0x42 received cleanly with count=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive checker (and the TX clock divider).
// Contents: receive FSM state encoding, data-bit count, default bit period.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   localparam int UART_DATA_BITS = 8;

   // 100 MHz system clock / 9600 Bd
   localparam int DEFAULT_CLKS_PER_BIT = 10416;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset; both flops load RST_VAL
//   d      - asynchronous input
//   q      - synchronised output, two clock cycles after d
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_checker.sv
// 8N1 UART receiver and loopback checker for the transmitter's serial line.
// Recovers each byte, compares it with the byte the TX side has latched and
// keeps good-byte and error counters for the seven-segment self-test display.
// Ports:
//   system_clock   - single clock for all logic
//   cpu_rst_n      - asynchronous active-low reset
//   rx             - serial input, idle high, asynchronous
//   expected_data  - reference byte, sampled at the stop-bit sample only
//   rx_data        - last good byte, held until the next good byte
//   rx_valid       - 1-cycle pulse when rx_data updates
//   frame_error    - 1-cycle pulse when the stop bit samples 0
//   mismatch       - 1-cycle pulse with rx_valid when the byte != expected_data
//   rx_busy        - high in any state except IDLE
//   rx_byte_count  - good bytes received, wraps
//   err_count      - framing errors + mismatches, saturates at all-ones
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | line idle, waiting for rx_s low
// START | half a bit into the start bit, confirm it is still low
// DATA  | sample eight data bits mid-bit, LSB first
// STOP  | sample stop bit mid-bit; good byte or framing error
// BREAK | line stuck low after a framing error, wait for it to go high
module uart_rx_checker
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int CNT_W        = 16
) (
   input  logic                      system_clock,
   input  logic                      cpu_rst_n,
   input  logic                      rx,
   input  logic [UART_DATA_BITS-1:0] expected_data,
   output logic [UART_DATA_BITS-1:0] rx_data,
   output logic                      rx_valid,
   output logic                      frame_error,
   output logic                      mismatch,
   output logic                      rx_busy,
   output logic [CNT_W-1:0]          rx_byte_count,
   output logic [CNT_W-1:0]          err_count
);

   localparam int TICK_W = $clog2(CLKS_PER_BIT);
   localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        IDX_LAST  = 3'(UART_DATA_BITS - 1);

   rx_state_t                 state, state_nxt;
   logic                      rx_s;
   logic [TICK_W-1:0]         tick;
   logic [2:0]                bit_idx, bit_idx_nxt;
   logic [UART_DATA_BITS-1:0] shift, shift_nxt;
   logic [UART_DATA_BITS-1:0] data_nxt;
   logic                      valid_nxt, ferr_nxt, mism_nxt;
   logic                      byte_inc, err_inc;

   sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
      .clk   (system_clock),
      .rst_n (cpu_rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   always_comb begin
      state_nxt   = state;
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      data_nxt    = rx_data;
      valid_nxt   = 1'b0;
      ferr_nxt    = 1'b0;
      mism_nxt    = 1'b0;
      byte_inc    = 1'b0;
      err_inc     = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) state_nxt = START;
         end
         START: begin
            // Timer restarts on entry to DATA, so every later sample is mid-bit.
            if (tick == TICK_HALF) state_nxt = rx_s ? IDLE : DATA;
         end
         DATA: begin
            if (tick == TICK_LAST) begin
               shift_nxt = {rx_s, shift[UART_DATA_BITS-1:1]};
               if (bit_idx == IDX_LAST) begin
                  bit_idx_nxt = 3'd0;
                  state_nxt   = STOP;
               end else begin
                  bit_idx_nxt = bit_idx + 3'd1;
               end
            end
         end
         STOP: begin
            // Leaving mid-stop-bit lets a back-to-back start edge be caught.
            if (tick == TICK_LAST) begin
               if (rx_s) begin
                  data_nxt  = shift;
                  valid_nxt = 1'b1;
                  byte_inc  = 1'b1;
                  mism_nxt  = (shift != expected_data);
                  err_inc   = mism_nxt;
                  state_nxt = IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  err_inc   = 1'b1;
                  state_nxt = BREAK;
               end
            end
         end
         BREAK: begin
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge system_clock or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Bit timer: restarts on every state change and wraps each bit period.
   always_ff @(posedge system_clock or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         tick <= '0;
      end else if (state_nxt != state || tick == TICK_LAST) begin
         tick <= '0;
      end else begin
         tick <= tick + 1'b1;
      end
   end

   always_ff @(posedge system_clock or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         bit_idx     <= 3'd0;
         shift       <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         frame_error <= 1'b0;
         mismatch    <= 1'b0;
      end else begin
         bit_idx     <= bit_idx_nxt;
         shift       <= shift_nxt;
         rx_data     <= data_nxt;
         rx_valid    <= valid_nxt;
         frame_error <= ferr_nxt;
         mismatch    <= mism_nxt;
      end
   end

   always_ff @(posedge system_clock or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         rx_byte_count <= '0;
         err_count     <= '0;
      end else begin
         if (byte_inc) rx_byte_count <= rx_byte_count + 1'b1;
         if (err_inc && err_count != {CNT_W{1'b1}}) err_count <= err_count + 1'b1;
      end
   end

   assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_checker.sv
// Directed bench for uart_rx_checker with a 16-cycle bit period.
module tb_uart_rx_checker;

   localparam int CPB   = 16;
   localparam int CNT_W = 16;

   logic             system_clock = 1'b0;
   logic             cpu_rst_n    = 1'b0;
   logic             rx           = 1'b1;
   logic [7:0]       expected_data = 8'h00;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             frame_error;
   logic             mismatch;
   logic             rx_busy;
   logic [CNT_W-1:0] rx_byte_count;
   logic [CNT_W-1:0] err_count;

   uart_rx_checker #(.CLKS_PER_BIT(CPB), .CNT_W(CNT_W)) dut (
      .system_clock  (system_clock),
      .cpu_rst_n     (cpu_rst_n),
      .rx            (rx),
      .expected_data (expected_data),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .frame_error   (frame_error),
      .mismatch      (mismatch),
      .rx_busy       (rx_busy),
      .rx_byte_count (rx_byte_count),
      .err_count     (err_count)
   );

   always #5 system_clock = ~system_clock;

   int cyc = 0;
   always @(posedge system_clock) cyc++;

   // Pulse monitor, sampled on the falling edge.
   int valid_cnt = 0, ferr_cnt = 0, mism_cnt = 0, bad_mism = 0, overlap = 0;
   int valid_cyc[$];
   always @(negedge system_clock) begin
      if (rx_valid) begin
         valid_cnt++;
         valid_cyc.push_back(cyc);
      end
      if (frame_error) ferr_cnt++;
      if (mismatch) begin
         mism_cnt++;
         if (!rx_valid) bad_mism++;
      end
      if (rx_valid && frame_error) overlap++;
   end

   int n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bit_out(input logic b);
      rx = b;
      repeat (CPB) @(posedge system_clock);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic stop);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(d[i]);
      bit_out(stop);
   endtask

   task automatic do_reset();
      rx = 1'b1;
      cpu_rst_n = 1'b0;
      repeat (3) @(posedge system_clock);
      #1;
      cpu_rst_n = 1'b1;
      repeat (3) @(posedge system_clock);
      #1;
   endtask

   task automatic settle();
      repeat (4) @(posedge system_clock);
      #1;
   endtask

   int v0, f0, m0, wait_n, gap;
   logic timed_out;
   logic [7:0] partial;

   initial begin
      // Reset state
      repeat (2) @(negedge system_clock);
      chk("rst_data",  rx_data, 0);
      chk("rst_valid", rx_valid, 0);
      chk("rst_ferr",  frame_error, 0);
      chk("rst_busy",  rx_busy, 0);
      chk("rst_bytes", rx_byte_count, 0);
      chk("rst_errs",  err_count, 0);
      @(posedge system_clock); #1;
      cpu_rst_n = 1'b1;
      repeat (3) @(posedge system_clock); #1;

      // Single good byte
      v0 = valid_cnt; m0 = mism_cnt;
      expected_data = 8'h55;
      send(8'h55, 1'b1);
      settle();
      chk("t1_pulses", valid_cnt - v0, 1);
      chk("t1_data",   rx_data, 8'h55);
      chk("t1_mism",   mism_cnt - m0, 0);
      chk("t1_bytes",  rx_byte_count, 1);
      chk("t1_errs",   err_count, 0);

      // Back-to-back frames
      do_reset();
      v0 = valid_cnt; m0 = mism_cnt;
      expected_data = 8'hA5;
      send(8'hA5, 1'b1);
      expected_data = 8'h3C;
      send(8'h3C, 1'b1);
      settle();
      chk("t2_pulses", valid_cnt - v0, 2);
      gap = (valid_cyc.size() >= 2) ? valid_cyc[$] - valid_cyc[$-1] : 0;
      chk("t2_spacing", gap, 160);
      chk("t2_data",   rx_data, 8'h3C);
      chk("t2_bytes",  rx_byte_count, 2);
      chk("t2_mism",   mism_cnt - m0, 0);
      chk("t2_errs",   err_count, 0);

      // Start-bit glitch of 6 cycles
      do_reset();
      v0 = valid_cnt; f0 = ferr_cnt;
      rx = 1'b0;
      repeat (6) @(posedge system_clock);
      #1;
      rx = 1'b1;
      chk("t3_busy_hi", rx_busy, 1);
      wait_n = 0;
      timed_out = 1'b0;
      while (rx_busy) begin
         @(posedge system_clock); #1;
         wait_n++;
         if (wait_n > 10) begin
            timed_out = 1'b1;
            break;
         end
      end
      chk("t3_busy_fall", timed_out, 0);
      settle();
      chk("t3_pulses", valid_cnt - v0, 0);
      chk("t3_ferr",   ferr_cnt - f0, 0);
      chk("t3_bytes",  rx_byte_count, 0);
      chk("t3_errs",   err_count, 0);

      // Framing error followed by a held-low line
      do_reset();
      expected_data = 8'h55;
      send(8'h55, 1'b1);
      v0 = valid_cnt; f0 = ferr_cnt;
      expected_data = 8'hF0;
      send(8'hF0, 1'b0);
      repeat (40) @(posedge system_clock);
      #1;
      chk("t4_ferr",     ferr_cnt - f0, 1);
      chk("t4_pulses",   valid_cnt - v0, 0);
      chk("t4_errs",     err_count, 1);
      chk("t4_data",     rx_data, 8'h55);
      chk("t4_bytes",    rx_byte_count, 1);
      chk("t4_break",    rx_busy, 1);
      rx = 1'b1;
      settle();
      chk("t4_idle",     rx_busy, 0);
      chk("t4_ferr_one", ferr_cnt - f0, 1);

      // Data mismatch
      do_reset();
      v0 = valid_cnt; m0 = mism_cnt;
      expected_data = 8'h18;
      send(8'h81, 1'b1);
      settle();
      chk("t5_pulses", valid_cnt - v0, 1);
      chk("t5_mism",   mism_cnt - m0, 1);
      chk("t5_data",   rx_data, 8'h81);
      chk("t5_errs",   err_count, 1);
      chk("t5_bytes",  rx_byte_count, 1);

      // Reset during bit 4, then a clean frame
      do_reset();
      expected_data = 8'h99;
      send(8'h99, 1'b1);
      v0 = valid_cnt; f0 = ferr_cnt;
      partial = 8'hC3;
      bit_out(1'b0);
      for (int i = 0; i < 4; i++) bit_out(partial[i]);
      rx = partial[4];
      repeat (8) @(posedge system_clock);
      #1;
      cpu_rst_n = 1'b0;
      @(negedge system_clock);
      chk("t6_rst_data",  rx_data, 0);
      chk("t6_rst_bytes", rx_byte_count, 0);
      chk("t6_rst_errs",  err_count, 0);
      chk("t6_rst_busy",  rx_busy, 0);
      rx = 1'b1;
      @(posedge system_clock); #1;
      cpu_rst_n = 1'b1;
      repeat (CPB * 8) @(posedge system_clock);
      #1;
      chk("t6_abort_pulses", valid_cnt - v0 + ferr_cnt - f0, 0);
      expected_data = 8'h42;
      send(8'h42, 1'b1);
      settle();
      chk("t6_pulses", valid_cnt - v0, 1);
      chk("t6_data",   rx_data, 8'h42);
      chk("t6_bytes",  rx_byte_count, 1);
      chk("t6_errs",   err_count, 0);

      // Pulse relationships over the whole run
      chk("mism_without_valid", bad_mism, 0);
      chk("valid_with_ferr",    overlap, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
